am_tx_arbiter: RTL

Transmit-side counterpart of the per-kernel handler demux. Merges up to 16 per-kernel outbound Active Message (AM) AXI-Stream ports into the single 64-bit GAScore AM stream. Arbitration is round-robin and packet-atomic, so packets from different kernels never interleave. Each header beat's source field is stamped with the sending kernel's global ID, `address_offset + index`.

---
 rtl/shoal_am_pkg.sv | 37 +++
 rtl/axis_pipe_reg.sv | 60 ++++++
 rtl/am_tx_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/shoal_am_pkg.sv
// -----------------------------------------------------------------------------
// shoal_am_pkg
// Shared definitions for the Active Message (AM) transmit path.
//   - Bit positions of the AM header fields inside a 64-bit header beat.
//   - State encoding of the transmit arbiter FSM.
//   - Helper that stamps a source ID into a header beat.
// No ports (package).
// -----------------------------------------------------------------------------
package shoal_am_pkg;

    localparam int AM_BEAT_WIDTH  = 32'd64;

    localparam int AM_HANDLER_HI  = 32'd59;
    localparam int AM_HANDLER_LO  = 32'd56;
    localparam int AM_DST_HI      = 32'd39;
    localparam int AM_DST_LO      = 32'd24;
    localparam int AM_SRC_HI      = 32'd23;
    localparam int AM_SRC_LO      = 32'd8;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } am_tx_state_e;

    // Replace only the source field of a header beat; every other bit is kept.
    function automatic logic [AM_BEAT_WIDTH-1:0] am_stamp_src(
        input logic [AM_BEAT_WIDTH-1:0] hdr,
        input logic [15:0]              src
    );
        logic [AM_BEAT_WIDTH-1:0] res;
        res = hdr;
        res[AM_SRC_HI:AM_SRC_LO] = src;
        return res;
    endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// -----------------------------------------------------------------------------
// axis_pipe_reg
// One-entry AXI-Stream register stage. Accepts a beat whenever it is empty or
// being drained in the same cycle, so a full register sustains one beat/cycle.
// Ports:
//   clock, reset_n          clock and synchronous active-low reset
//   in_data/in_last         beat offered by the upstream side
//   in_valid                upstream valid
//   in_ready                register can accept this cycle (!out_valid | out_ready)
//   out_data/out_last/out_valid  registered stream towards downstream
//   out_ready               downstream ready
// -----------------------------------------------------------------------------
module axis_pipe_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] data_r;
    logic             last_r;
    logic             valid_r;
    logic             in_ready_s;

    // Room for a new beat when empty or when the held beat leaves this cycle.
    always_comb begin
        in_ready_s = ~valid_r | out_ready;
    end

    // Storage: load on input handshake, otherwise drop valid once drained.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_r  <= '0;
            last_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (in_valid && in_ready_s) begin
            data_r  <= in_data;
            last_r  <= in_last;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = data_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/am_tx_arbiter.sv
// -----------------------------------------------------------------------------
// am_tx_arbiter
// Merges NUM_KERNELS per-kernel outbound AM streams into one 64-bit stream.
// Round-robin, packet-atomic: once a kernel is granted, all beats up to its
// tlast are forwarded before another kernel is considered. The header beat of
// each packet gets its source field replaced by address_offset + kernel index.
// Ports:
//   clock, reset_n     clock and synchronous active-low reset
//   s_axis_tdata       kernel k beat in [64k+63:64k]
//   s_axis_tlast       per-kernel end of packet
//   s_axis_tvalid      per-kernel valid
//   s_axis_tready      per-kernel ready, at most one bit set
//   m_axis_*           merged, registered AM stream
//   address_offset     global ID of kernel 0 (static while running)
// -----------------------------------------------------------------------------
module am_tx_arbiter
    import shoal_am_pkg::*;
#(
    parameter int NUM_KERNELS = 2,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_KERNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_KERNELS-1:0]            s_axis_tlast,
    input  logic [NUM_KERNELS-1:0]            s_axis_tvalid,
    output logic [NUM_KERNELS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    input  logic [15:0]                       address_offset
);

    localparam int KERNEL_WIDTH = (NUM_KERNELS == 32'sd1) ? 32'sd1 : $clog2(NUM_KERNELS);

    am_tx_state_e            state_r;
    logic [KERNEL_WIDTH-1:0] grant_r;
    logic [KERNEL_WIDTH-1:0] last_grant_r;

    logic                    active_s;
    logic [DATA_WIDTH-1:0]   raw_beat_s;
    logic [DATA_WIDTH-1:0]   beat_s;
    logic                    beat_last_s;
    logic                    beat_valid_s;
    logic                    out_ready_s;
    logic                    in_fire_s;
    logic [NUM_KERNELS-1:0]  ready_s;

    // First requester found by walking cyclically from the kernel after 'last'.
    function automatic logic [KERNEL_WIDTH-1:0] rr_pick(
        input logic [NUM_KERNELS-1:0]  valid,
        input logic [KERNEL_WIDTH-1:0] last
    );
        logic [KERNEL_WIDTH-1:0] pick;
        logic [KERNEL_WIDTH-1:0] idx;
        logic                    found;
        pick  = '0;
        found = 1'b0;
        for (int i = 32'sd1; i <= NUM_KERNELS; i++) begin
            idx = KERNEL_WIDTH'((int'(last) + i) % NUM_KERNELS);
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Datapath mux from the granted kernel, with source stamping on the header.
    always_comb begin
        active_s     = (state_r == ST_HEADER) || (state_r == ST_PAYLOAD);
        raw_beat_s   = s_axis_tdata[DATA_WIDTH*int'(grant_r) +: DATA_WIDTH];
        beat_s       = (state_r == ST_HEADER)
                       ? am_stamp_src(raw_beat_s, address_offset + 16'(grant_r))
                       : raw_beat_s;
        beat_last_s  = s_axis_tlast[grant_r];
        beat_valid_s = active_s & s_axis_tvalid[grant_r];
        in_fire_s    = beat_valid_s & out_ready_s;
    end

    // Only the granted kernel sees ready, and only outside arbitration.
    always_comb begin
        ready_s = '0;
        if (active_s && out_ready_s) begin
            ready_s[grant_r] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    assign s_axis_tready = ready_s;

    // Arbitration FSM: pick a kernel, take its header, then stream until tlast.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r      <= ST_ARB;
            grant_r      <= '0;
            last_grant_r <= KERNEL_WIDTH'(NUM_KERNELS - 32'sd1);
        end else begin
            case (state_r)
                ST_ARB: begin
                    if (|s_axis_tvalid) begin
                        grant_r <= rr_pick(s_axis_tvalid, last_grant_r);
                        state_r <= ST_HEADER;
                    end else begin
                        state_r <= ST_ARB;
                    end
                end
                ST_HEADER: begin
                    if (in_fire_s) begin
                        last_grant_r <= grant_r;
                        state_r      <= beat_last_s ? ST_ARB : ST_PAYLOAD;
                    end else begin
                        state_r <= ST_HEADER;
                    end
                end
                ST_PAYLOAD: begin
                    if (in_fire_s && beat_last_s) begin
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                default: begin
                    state_r <= ST_ARB;
                end
            endcase
        end
    end

    axis_pipe_reg #(
        .WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_data   (beat_s),
        .in_last   (beat_last_s),
        .in_valid  (beat_valid_s),
        .in_ready  (out_ready_s),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule
